// File: rtl/simd_execute.sv
// simd_execute: SIMD execute/writeback stage with one-entry result register.
// Define SIMD_SATURATE_EN to clamp results to the DBW signed range instead of truncating.
module simd_execute #(
  parameter int VSIZE    = 32,
  parameter int DBW      = 16,
  parameter int TDBW     = 24,
  parameter int SRAM_ABW = 9,
  parameter int WBW      = 16,
  parameter int DIM      = 5
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic                               op_rdy,
  output logic                               op_ack,
  input  logic [2:0]                         i_opcode,
  input  logic [4:0]                         i_shamt,
  input  logic [DIM-1:0][WBW-1:0]            i_bofs,
  input  logic [DIM-1:0][WBW-1:0]            i_aofs,
  input  logic [TDBW-1:0]                    i_const_a,
  input  logic [TDBW-1:0]                    i_const_b,
  input  logic [TDBW-1:0]                    i_const_c,
  input  logic [2:0]                         i_a,
  input  logic [2:0]                         i_b,
  input  logic [2:0]                         i_c,
  input  logic                               i_to_reg,
  input  logic [1:0]                         i_to_dram,
  input  logic                               i_to_temp,
  input  logic [SRAM_ABW-1:0]                i_reg_waddr,
  input  logic [VSIZE-1:0][DBW-1:0]          i_reg_rdata,
  input  logic [1:0][VSIZE-1:0][DBW-1:0]     i_dram,
  input  logic [1:0][VSIZE-1:0][DBW-1:0]     i_temp,
  output logic                               res_rdy,
  input  logic                               res_ack,
  output logic [VSIZE-1:0][DBW-1:0]          o_res,
  output logic [DIM-1:0][WBW-1:0]            o_bofs,
  output logic [DIM-1:0][WBW-1:0]            o_aofs,
  output logic [1:0]                         o_to_dram,
  output logic                               o_to_temp,
  output logic                               o_reg_we,
  output logic [SRAM_ABW-1:0]                o_reg_waddr,
  output logic [VSIZE-1:0][DBW-1:0]          o_reg_wdata
);
  typedef enum logic {IDLE, FULL} state_t;
  state_t state, nxt;
  logic rvalid, r_to_reg, reg_only, retire;
  logic [VSIZE-1:0][DBW-1:0] hold, nres;

  function automatic logic signed [TDBW-1:0] sx(input logic [DBW-1:0] v);
    return {{(TDBW-DBW){v[DBW-1]}}, v};
  endfunction

  function automatic logic signed [TDBW-1:0] pick(input logic [2:0] s, input logic [TDBW-1:0] k,
                                                   input logic [DBW-1:0] rg, d0, d1, t0, t1);
    return s == 3'd0 ? k : s == 3'd1 ? sx(rg) : s == 3'd2 ? sx(d0) : s == 3'd3 ? sx(d1) :
           s == 3'd4 ? sx(t0) : s == 3'd5 ? sx(t1) : '0;
  endfunction

  for (genvar l = 0; l < VSIZE; l++) begin : g_lane
    logic signed [TDBW-1:0] a, b, c, p, r;
    logic [DBW-1:0] rg;
    always_comb begin
      rg = rvalid ? hold[l] : i_reg_rdata[l];
      a = pick(i_a, i_const_a, rg, i_dram[0][l], i_dram[1][l], i_temp[0][l], i_temp[1][l]);
      b = pick(i_b, i_const_b, rg, i_dram[0][l], i_dram[1][l], i_temp[0][l], i_temp[1][l]);
      c = pick(i_c, i_const_c, rg, i_dram[0][l], i_dram[1][l], i_temp[0][l], i_temp[1][l]);
      p = a * b;
      r = i_opcode == 3'd0 ? (p + c) >>> i_shamt :
          i_opcode == 3'd1 ? (a + b + c) >>> i_shamt :
          i_opcode == 3'd2 ? (a > b ? a : b) + c :
          i_opcode == 3'd3 ? (a < b ? a : b) + c :
          i_opcode == 3'd4 ? (a & b) | c :
          i_opcode == 3'd5 ? a ^ b ^ c :
          i_opcode == 3'd6 ? (a < b ? b : c) :
          (a == '0 ? b : c);
`ifdef SIMD_SATURATE_EN
      nres[l] = (&r[TDBW-1:DBW-1] || ~|r[TDBW-1:DBW-1]) ? r[DBW-1:0] :
                r[TDBW-1] ? {1'b1, {(DBW-1){1'b0}}} : {1'b0, {(DBW-1){1'b1}}};
`else
      nres[l] = r[DBW-1:0];
`endif
    end
  end

  // register-only ops never see res_ack, so they retire on their own
  assign reg_only = o_to_dram == 2'b11 && !o_to_temp;
  assign o_reg_wdata = o_res;

  always_comb begin
    retire = state == FULL && (res_ack || reg_only);
    op_ack = op_rdy && (state == IDLE || res_ack);
    res_rdy = state == FULL && !reg_only;
    o_reg_we = retire && r_to_reg;
    nxt = op_ack ? FULL : retire ? IDLE : state;
  end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= IDLE;
    else state <= nxt;

  // read data is only valid on the first op_rdy cycle; keep it for stalled cycles
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      rvalid <= 1'b0;
      hold <= '0;
      o_res <= '0;
      o_bofs <= '0;
      o_aofs <= '0;
      o_to_dram <= 2'b11;
      o_to_temp <= 1'b0;
      r_to_reg <= 1'b0;
      o_reg_waddr <= '0;
    end else begin
      rvalid <= op_rdy && !op_ack;
      if (op_rdy && !rvalid) hold <= i_reg_rdata;
      if (op_ack) begin
        o_res <= nres;
        o_bofs <= i_bofs;
        o_aofs <= i_aofs;
        o_to_dram <= i_to_dram;
        o_to_temp <= i_to_temp;
        r_to_reg <= i_to_reg;
        o_reg_waddr <= i_reg_waddr;
      end
    end
endmodule

// File: tb/tb_simd_execute.sv
// tb_simd_execute: table vectors, directed handshake sequences and a random back-to-back
// stream checked against an arithmetic lane model.
module tb_simd_execute;
  localparam int V = 32, D = 16, T = 24, A = 9, W = 16, N = 5;
  logic clk = 0, rst_n = 0;
  logic op_rdy = 0, op_ack, res_rdy, res_ack = 0;
  logic [2:0] opcode, sa, sb, sc;
  logic [4:0] shamt;
  logic [N-1:0][W-1:0] bofs, aofs, o_bofs, o_aofs;
  logic [T-1:0] ka, kb, kc;
  logic to_reg, to_temp, o_to_temp, o_reg_we;
  logic [1:0] to_dram, o_to_dram;
  logic [A-1:0] waddr, o_reg_waddr;
  logic [V-1:0][D-1:0] reg_rdata, o_res, o_reg_wdata, expv, first_rd;
  logic [1:0][V-1:0][D-1:0] dram, temp;
  logic [2:0] e_flags;
  logic [A-1:0] e_waddr;
  logic [N-1:0][W-1:0] e_bofs, e_aofs;
  int checks = 0, failures = 0;

  simd_execute dut (
    .i_clk(clk), .i_rst_n(rst_n), .op_rdy(op_rdy), .op_ack(op_ack),
    .i_opcode(opcode), .i_shamt(shamt), .i_bofs(bofs), .i_aofs(aofs),
    .i_const_a(ka), .i_const_b(kb), .i_const_c(kc), .i_a(sa), .i_b(sb), .i_c(sc),
    .i_to_reg(to_reg), .i_to_dram(to_dram), .i_to_temp(to_temp), .i_reg_waddr(waddr),
    .i_reg_rdata(reg_rdata), .i_dram(dram), .i_temp(temp),
    .res_rdy(res_rdy), .res_ack(res_ack), .o_res(o_res), .o_bofs(o_bofs), .o_aofs(o_aofs),
    .o_to_dram(o_to_dram), .o_to_temp(o_to_temp), .o_reg_we(o_reg_we),
    .o_reg_waddr(o_reg_waddr), .o_reg_wdata(o_reg_wdata)
  );

  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  typedef struct {
    logic [2:0] op; logic [4:0] sh; logic [2:0] a, b, c;
    logic [T-1:0] ka, kb, kc; logic [D-1:0] rv, ex;
  } vec_t;
  vec_t tbl[15];

  function automatic longint s16(input logic [D-1:0] v);
    return v[D-1] ? longint'(v) - 65536 : longint'(v);
  endfunction
  function automatic longint s24(input logic [T-1:0] v);
    return v[T-1] ? longint'(v) - 16777216 : longint'(v);
  endfunction
  function automatic longint wr(input longint x);
    longint y;
    y = x % 16777216;
    if (y < 0) y += 16777216;
    return y >= 8388608 ? y - 16777216 : y;
  endfunction
  function automatic longint src(input logic [2:0] s, input logic [T-1:0] k, input int i,
                                 input logic [V-1:0][D-1:0] rg);
    case (s)
      3'd0: return s24(k);
      3'd1: return s16(rg[i]);
      3'd2: return s16(dram[0][i]);
      3'd3: return s16(dram[1][i]);
      3'd4: return s16(temp[0][i]);
      3'd5: return s16(temp[1][i]);
      default: return 0;
    endcase
  endfunction
  function automatic logic [V-1:0][D-1:0] model(input logic [V-1:0][D-1:0] rg);
    logic [V-1:0][D-1:0] r;
    longint a, b, c, x;
    for (int i = 0; i < V; i++) begin
      a = src(sa, ka, i, rg); b = src(sb, kb, i, rg); c = src(sc, kc, i, rg);
      case (opcode)
        3'd0: x = wr(wr(a * b) + c) >>> shamt;
        3'd1: x = wr(a + b + c) >>> shamt;
        3'd2: x = wr((a > b ? a : b) + c);
        3'd3: x = wr((a < b ? a : b) + c);
        3'd4: x = wr((a & b) | c);
        3'd5: x = wr(a ^ b ^ c);
        3'd6: x = a < b ? b : c;
        default: x = a == 0 ? b : c;
      endcase
`ifdef SIMD_SATURATE_EN
      x = x > 32767 ? 32767 : x < -32768 ? -32768 : x;
`endif
      r[i] = x[D-1:0];
    end
    return r;
  endfunction

  task automatic chk(input string n, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask
  task automatic nxt();
    @(posedge clk); #1;
  endtask
  task automatic wait_ack(input string n);
    int k;
    k = 0;
    @(negedge clk);
    while (!op_ack && k < 20) begin @(negedge clk); k++; end
    chk({n, "_ack"}, op_ack, 1'b1);
  endtask
  task automatic clr();
    opcode = 0; shamt = 0; sa = 0; sb = 0; sc = 0; ka = 0; kb = 0; kc = 0;
    bofs = '0; aofs = '0; to_reg = 0; to_dram = 0; to_temp = 0; waddr = 0;
    reg_rdata = '0; dram = '0; temp = '0;
  endtask
  task automatic rnd();
    opcode = 3'($urandom); shamt = 5'($urandom); sa = 3'($urandom); sb = 3'($urandom);
    sc = 3'($urandom); ka = T'($urandom); kb = T'($urandom); kc = T'($urandom);
    to_reg = 1'($urandom); to_dram = 2'($urandom); to_temp = 1'($urandom); waddr = A'($urandom);
    for (int i = 0; i < N; i++) begin bofs[i] = W'($urandom); aofs[i] = W'($urandom); end
    for (int i = 0; i < V; i++) begin
      reg_rdata[i] = D'($urandom);
      for (int j = 0; j < 2; j++) begin dram[j][i] = D'($urandom); temp[j][i] = D'($urandom); end
    end
  endtask
  task automatic chk_rst(input string n);
    chk({n, "_res"}, {o_res, o_reg_wdata}, '0);
    chk({n, "_flags"}, {res_rdy, o_reg_we, o_to_dram, o_to_temp, o_reg_waddr}, {4'b0011, 1'b0, 9'd0});
    chk({n, "_ofs"}, {o_bofs, o_aofs}, '0);
  endtask

  initial begin
`ifdef SIMD_SATURATE_EN
    tbl[1] = '{3'd0, 5'd0, 3'd0, 3'd0, 3'd0, 24'd300, 24'd300, 24'd0, 16'd0, 16'h7FFF};
    tbl[2] = '{3'd0, 5'd0, 3'd0, 3'd0, 3'd0, 24'hFFFED4, 24'd300, 24'd0, 16'd0, 16'h8000};
`else
    tbl[1] = '{3'd0, 5'd0, 3'd0, 3'd0, 3'd0, 24'd300, 24'd300, 24'd0, 16'd0, 16'd24464};
    tbl[2] = '{3'd0, 5'd0, 3'd0, 3'd0, 3'd0, 24'hFFFED4, 24'd300, 24'd0, 16'd0, 16'hA070};
`endif
    tbl[0]  = '{3'd0, 5'd0, 3'd0, 3'd1, 3'd0, 24'd3, 24'd0, 24'd1, 16'd5, 16'd16};
    tbl[3]  = '{3'd0, 5'd2, 3'd0, 3'd0, 3'd0, 24'hFFFF9C, 24'd3, 24'd0, 16'd0, 16'hFFB5};
    tbl[4]  = '{3'd1, 5'd1, 3'd0, 3'd0, 3'd0, 24'hFFFFF9, 24'd0, 24'd0, 16'd0, 16'hFFFC};
    tbl[5]  = '{3'd2, 5'd0, 3'd0, 3'd1, 3'd0, 24'hFFFFFB, 24'd0, 24'd1, 16'd7, 16'd8};
    tbl[6]  = '{3'd3, 5'd0, 3'd0, 3'd1, 3'd0, 24'hFFFFFB, 24'd0, 24'd1, 16'd7, 16'hFFFC};
    tbl[7]  = '{3'd4, 5'd0, 3'd0, 3'd0, 3'd0, 24'h000F0F, 24'h0000FF, 24'h001000, 16'd0, 16'h100F};
    tbl[8]  = '{3'd5, 5'd0, 3'd0, 3'd0, 3'd0, 24'h001234, 24'h0000FF, 24'h000F00, 16'd0, 16'h1DCB};
    tbl[9]  = '{3'd6, 5'd0, 3'd0, 3'd0, 3'd0, 24'd3, 24'd9, 24'd77, 16'd0, 16'd9};
    tbl[10] = '{3'd6, 5'd0, 3'd0, 3'd0, 3'd0, 24'd9, 24'd3, 24'd77, 16'd0, 16'd77};
    tbl[11] = '{3'd7, 5'd0, 3'd0, 3'd0, 3'd0, 24'd0, 24'd42, 24'hFFFFFF, 16'd0, 16'd42};
    tbl[12] = '{3'd7, 5'd0, 3'd0, 3'd0, 3'd0, 24'd1, 24'd42, 24'hFFFFFF, 16'd0, 16'hFFFF};
    tbl[13] = '{3'd1, 5'd0, 3'd6, 3'd7, 3'd0, 24'd1000, 24'd1000, 24'd5, 16'd0, 16'd5};
    tbl[14] = '{3'd1, 5'd4, 3'd1, 3'd0, 3'd0, 24'd0, 24'd0, 24'd0, 16'h8000, 16'hF800};
    clr();
    #12;
    chk_rst("reset");
    rst_n = 1;
    nxt();

    // opcode table, res path, res_ack held high
    res_ack = 1;
    for (int e = 0; e < 15; e++) begin
      clr();
      opcode = tbl[e].op; shamt = tbl[e].sh; sa = tbl[e].a; sb = tbl[e].b; sc = tbl[e].c;
      ka = tbl[e].ka; kb = tbl[e].kb; kc = tbl[e].kc; reg_rdata = {V{tbl[e].rv}};
      to_reg = 1; waddr = A'(e); op_rdy = 1;
      wait_ack($sformatf("tbl%0d", e));
      nxt();
      op_rdy = 0;
      chk($sformatf("tbl%0d_res", e), o_res, {V{tbl[e].ex}});
      chk($sformatf("tbl%0d_hs", e), {res_rdy, o_reg_we, o_reg_waddr}, {2'b11, A'(e)});
      nxt();
    end

    // register-only op retires by itself one cycle after acceptance
    res_ack = 0;
    clr();
    opcode = 0; ka = 3; sb = 1; kc = 1; reg_rdata = {V{16'd5}};
    to_reg = 1; to_dram = 2'b11; waddr = 9'h12; op_rdy = 1;
    wait_ack("regonly");
    chk("regonly_rdy0", res_rdy, 1'b0);
    nxt();
    op_rdy = 0;
    chk("regonly_we", {o_reg_we, res_rdy, o_reg_waddr}, {2'b10, 9'h12});
    chk("regonly_wdata", o_reg_wdata, {V{16'd16}});
    nxt();
    chk("regonly_after", {o_reg_we, res_rdy}, 2'b00);

    // stall with res_ack low; a queued op keeps its first-cycle register data
    clr();
    opcode = 1; shamt = 1; sa = 2; sb = 5; sc = 0;
    for (int i = 0; i < V; i++) begin dram[0][i] = D'(i); temp[1][i] = 16'd2; end
    op_rdy = 1;
    wait_ack("stall");
    expv = model(reg_rdata);
    for (int i = 0; i < V; i++) chk("stall_model", expv[i], D'((i + 2) >> 1));
    nxt();
    clr();
    opcode = 0; ka = 2; sb = 1; reg_rdata = {V{16'd7}}; first_rd = reg_rdata;
    to_reg = 1; to_dram = 1; waddr = 9'h33;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("stall_ack_low", {op_ack, res_rdy, o_reg_we}, 3'b010);
      chk("stall_res", o_res, expv);
      nxt();
      reg_rdata = {V{16'd1000}};
    end
    res_ack = 1;
    @(negedge clk);
    chk("stall_release", {op_ack, res_rdy, o_reg_we}, 3'b110);
    chk("stall_res_final", o_res, expv);
    expv = model(first_rd);
    nxt();
    op_rdy = 0;
    chk("hold_res", o_res, expv);
    chk("hold_res_const", o_res, {V{16'd14}});
    chk("hold_hs", {res_rdy, o_reg_we, o_reg_waddr}, {2'b11, 9'h33});
    nxt();
    chk("hold_idle", {res_rdy, o_reg_we}, 2'b00);

    // random back-to-back stream, res_ack tied high
    rnd();
    op_rdy = 1;
    for (int k = 0; k < 40; k++) begin
      expv = model(reg_rdata);
      e_flags = {to_reg, to_dram == 2'b11 && !to_temp, 1'b0};
      e_waddr = waddr; e_bofs = bofs; e_aofs = aofs;
      e_flags[0] = to_temp;
      @(negedge clk);
      chk("b2b_ack", op_ack, 1'b1);
      nxt();
      chk("b2b_res", o_res, expv);
      chk("b2b_flags", {res_rdy, o_reg_we, o_to_temp, o_reg_waddr},
          {!e_flags[1], e_flags[2], e_flags[0], e_waddr});
      chk("b2b_ofs", {o_bofs, o_aofs}, {e_bofs, e_aofs});
      if (k == 39) op_rdy = 0;
      else rnd();
    end
    nxt();
    chk("b2b_idle", {res_rdy, o_reg_we}, 2'b00);

    // asynchronous reset while R holds a register-writing op
    res_ack = 0;
    clr();
    opcode = 1; ka = 5; to_reg = 1; to_dram = 0; waddr = 9'h55; bofs[0] = 16'hBEEF; op_rdy = 1;
    wait_ack("rstfull");
    nxt();
    op_rdy = 0;
    chk("rstfull_pre", {res_rdy, o_reg_we, o_reg_waddr}, {2'b10, 9'h55});
    #2;
    rst_n = 0; res_ack = 1;
    #1;
    chk_rst("rst_async");
    nxt();
    chk_rst("rst_held");
    @(negedge clk);
    rst_n = 1;
    nxt();
    chk_rst("rst_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
